// File: rtl/ccff_loader_pkg.sv
// Shared types for the configuration-chain loader: FSM state encoding and word-count helper.
// No logic; imported by the loader top.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/ccff_piso.sv
// Parallel-in/serial-out word register; ser_out is registered and holds when neither load nor shift.
// Load presents the MSB next cycle; each shift presents the next lower bit while bits_left > 0.
module ccff_piso #(
  parameter int WORD_W = 16,
  parameter int LEFT_W = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic              shift,
  output logic              ser_out,
  output logic [LEFT_W-1:0] bits_left
);

  logic [WORD_W-1:0] sreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg      <= '0;
      ser_out   <= 1'b0;
      bits_left <= '0;
    end else if (load) begin
      ser_out   <= load_data[WORD_W-1];
      sreg      <= load_data << 1;
      bits_left <= LEFT_W'(WORD_W - 1);
    end else if (shift && (bits_left != '0)) begin
      ser_out   <= sreg[WORD_W-1];
      sreg      <= sreg << 1;
      bits_left <= bits_left - LEFT_W'(1);
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Serialises exactly CHAIN_LEN bits onto ccff_head; first bit one cycle after a word handshake, no bubble back-to-back.
// Optional CCFF_READBACK_EN adds rb_data/rb_valid capture of ccff_tail; a stalled word_valid idles the chain.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter  int WORD_W    = 16,
  parameter  int CHAIN_LEN = 16,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done
`ifdef CCFF_READBACK_EN
  ,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
`endif
);

  localparam int NUM_WORDS = ceil_div(CHAIN_LEN, WORD_W);
  localparam int WC_W      = $clog2(NUM_WORDS + 1);
  localparam int LEFT_W    = $clog2(WORD_W + 1);

  if (CHAIN_LEN < 1) begin : g_bad_chain_len
    $error("ccff_chain_loader: CHAIN_LEN must be at least 1");
  end

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WC_W-1:0]   word_cnt;
  logic [LEFT_W-1:0] bits_left;
  logic              load, shift, shift_en_q;
  logic              chain_left, words_left;

  assign chain_left = bit_cnt < CNT_W'(CHAIN_LEN);
  assign words_left = word_cnt < WC_W'(NUM_WORDS);

  always_comb begin
    state_nxt  = state;
    word_ready = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: begin
        word_ready = words_left;
        if (word_valid && words_left) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (!chain_left) begin
          state_nxt = DONE;
        end else if (bits_left != '0) begin
          shift = 1'b1;
        end else begin
          // last bit of this word is on the head: take the next word now to avoid a bubble
          word_ready = words_left;
          if (word_valid && words_left) load = 1'b1;
          else                          state_nxt = LOAD;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt  = IDLE;
      word_ready = 1'b0;
      load       = 1'b0;
      shift      = 1'b0;
    end
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state      <= IDLE;
      shift_en_q <= 1'b0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      shift_en_q <= load | shift;
      if ((state == IDLE) && start && !abort) begin
        bit_cnt  <= '0;
        word_cnt <= '0;
      end else begin
        if ((load | shift) && chain_left) bit_cnt <= bit_cnt + CNT_W'(1);
        if (load) word_cnt <= word_cnt + WC_W'(1);
      end
    end
  end

  ccff_piso #(.WORD_W(WORD_W), .LEFT_W(LEFT_W)) u_piso (
    .clk       (prog_clk),
    .rst_n     (prog_reset_n),
    .load      (load),
    .load_data (word_data),
    .shift     (shift),
    .ser_out   (ccff_head),
    .bits_left (bits_left)
  );

  assign ccff_shift_en = shift_en_q;
  assign busy          = (state == LOAD) || (state == SHIFT);
  assign done          = (state == DONE);

`ifdef CCFF_READBACK_EN
  logic [WORD_W-1:0] rb_acc, rb_acc_nxt;
  logic [LEFT_W-1:0] rb_cnt, rb_pad;
  logic              rb_last;

  assign rb_acc_nxt = (rb_acc << 1) | WORD_W'(ccff_tail);
  assign rb_pad     = LEFT_W'(WORD_W - 1) - rb_cnt;
  // a group closes on a full word or on the final chain bit (partial group, left-aligned)
  assign rb_last    = (rb_cnt == LEFT_W'(WORD_W - 1)) || !chain_left;

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      rb_acc   <= '0;
      rb_cnt   <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (state == IDLE) begin
        rb_cnt <= '0;
      end else if (ccff_shift_en) begin
        rb_acc <= rb_acc_nxt;
        if (rb_last) begin
          rb_data  <= rb_acc_nxt << rb_pad;
          rb_valid <= 1'b1;
          rb_cnt   <= '0;
        end else begin
          rb_cnt <= rb_cnt + LEFT_W'(1);
        end
      end
    end
  end
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench: a 16/16 loader (with a chain model on its tail) and a 20-bit chain / 16-bit word loader.
module tb_ccff_chain_loader;

  logic prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  logic        prog_reset_n;
  logic        a_start, a_abort, a_valid, a_ready, a_head, a_shift_en, a_tail, a_busy, a_done;
  logic [15:0] a_data;
  logic        b_start, b_abort, b_valid, b_ready, b_head, b_shift_en, b_tail, b_busy, b_done;
  logic [15:0] b_data;
`ifdef CCFF_READBACK_EN
  logic [15:0] a_rb_data, b_rb_unused_data;
  logic        a_rb_valid, b_rb_unused_vld;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  // simple 16-flop chain behind DUT a
  logic [15:0] chain = '0;
  logic        chain_clr = 1'b0;
  always @(posedge prog_clk) begin
    if (chain_clr)       chain <= '0;
    else if (a_shift_en) chain <= {chain[14:0], a_head};
  end
  assign a_tail = chain[15];
  assign b_tail = 1'b0;

  ccff_chain_loader #(.WORD_W(16), .CHAIN_LEN(16)) dut_a (
    .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .start(a_start), .abort(a_abort),
    .word_data(a_data), .word_valid(a_valid), .word_ready(a_ready), .ccff_head(a_head),
    .ccff_shift_en(a_shift_en), .ccff_tail(a_tail), .busy(a_busy), .done(a_done)
`ifdef CCFF_READBACK_EN
    , .rb_data(a_rb_data), .rb_valid(a_rb_valid)
`endif
  );

  ccff_chain_loader #(.WORD_W(16), .CHAIN_LEN(20)) dut_b (
    .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .start(b_start), .abort(b_abort),
    .word_data(b_data), .word_valid(b_valid), .word_ready(b_ready), .ccff_head(b_head),
    .ccff_shift_en(b_shift_en), .ccff_tail(b_tail), .busy(b_busy), .done(b_done)
`ifdef CCFF_READBACK_EN
    , .rb_data(b_rb_unused_data), .rb_valid(b_rb_unused_vld)
`endif
  );

  task automatic tick;
    @(posedge prog_clk);
    #2;
  endtask

  task automatic test_reset;
    prog_reset_n = 1'b0;
    {a_start, a_abort, a_valid, b_start, b_abort, b_valid} = '0;
    a_data = '0;
    b_data = '0;
    #12;
    vec_cnt++;
    if ({a_ready, a_head, a_shift_en, a_busy, a_done} !== 5'b0) begin
      err_cnt++;
      $display("FAIL reset_a: outputs=%b want 00000", {a_ready, a_head, a_shift_en, a_busy, a_done});
    end
    vec_cnt++;
    if ({b_ready, b_head, b_shift_en, b_busy, b_done} !== 5'b0) begin
      err_cnt++;
      $display("FAIL reset_b: outputs=%b want 00000", {b_ready, b_head, b_shift_en, b_busy, b_done});
    end
    tick;
    prog_reset_n = 1'b1;
    tick;
  endtask

  // start in cycle 0, word in cycle 1, bits in 2..17, done in 18; a stray start in cycle 5 is ignored
  task automatic test_single_word(input logic [15:0] w);
    a_start = 1'b1;
    tick;
    vec_cnt++;
    if ({a_ready, a_busy} !== 2'b11) begin
      err_cnt++;
      $display("FAIL single_load: ready,busy=%b want 11", {a_ready, a_busy});
    end
    a_start = 1'b0;
    a_valid = 1'b1;
    a_data  = w;
    for (int i = 0; i < 16; i++) begin
      tick;
      a_valid = 1'b0;
      a_start = (i == 3);
      vec_cnt++;
      if ({a_head, a_shift_en, a_ready} !== {w[15-i], 1'b1, 1'b0}) begin
        err_cnt++;
        $display("FAIL single_bit%0d: head,shift_en,ready=%b want %b", i,
                 {a_head, a_shift_en, a_ready}, {w[15-i], 2'b10});
      end
    end
    tick;
    a_start = 1'b0;
    vec_cnt++;
    if ({a_done, a_shift_en, a_busy} !== 3'b100) begin
      err_cnt++;
      $display("FAIL single_done: done,shift_en,busy=%b want 100", {a_done, a_shift_en, a_busy});
    end
    tick;
    vec_cnt++;
    if ({a_done, a_busy} !== 2'b00) begin
      err_cnt++;
      $display("FAIL single_after: done,busy=%b want 00", {a_done, a_busy});
    end
  endtask

  // 20-bit chain with words 0xFFFF, 0xA000; gap = cycles word_valid stays low between words
  task automatic test_two_words(input int gap);
    logic [19:0] stream;
    int hs, shifts, first, last, done_n, done_cyc, late_rdy;
    stream = {16'hFFFF, 4'hA};
    hs = 0; shifts = 0; first = -1; last = -1; done_n = 0; done_cyc = -1; late_rdy = 0;
    b_start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick;
      b_start = 1'b0;
      if (b_shift_en) begin
        if (shifts < 20) begin
          vec_cnt++;
          if (b_head !== stream[19-shifts]) begin
            err_cnt++;
            $display("FAIL two_words_gap%0d_bit%0d: head=%b want %b", gap, shifts, b_head, stream[19-shifts]);
          end
        end
        if (first < 0) first = c;
        last = c;
        shifts++;
      end else if (shifts > 0 && shifts < 20) begin
        vec_cnt++;
        if (b_head !== stream[20-shifts]) begin
          err_cnt++;
          $display("FAIL stall_hold_c%0d: head=%b want %b", c, b_head, stream[20-shifts]);
        end
      end
      if (b_done) begin
        done_n++;
        done_cyc = c;
      end
      if (hs >= 2 && b_ready) late_rdy++;
      b_valid = (hs == 0) || (hs == 1 && c >= 17 + gap);
      b_data  = (hs == 0) ? 16'hFFFF : 16'hA000;
      if (b_valid && b_ready) hs++;
    end
    b_valid = 1'b0;
    vec_cnt++;
    if (hs !== 2) begin
      err_cnt++;
      $display("FAIL handshakes_gap%0d: got %0d want 2", gap, hs);
    end
    vec_cnt++;
    if (shifts !== 20) begin
      err_cnt++;
      $display("FAIL shift_count_gap%0d: got %0d want 20", gap, shifts);
    end
    vec_cnt++;
    if (first !== 2 || last - first !== 19 + gap) begin
      err_cnt++;
      $display("FAIL shift_span_gap%0d: first=%0d last=%0d want first=2 last=%0d", gap, first, last, 21 + gap);
    end
    vec_cnt++;
    if (done_n !== 1 || done_cyc !== last + 1) begin
      err_cnt++;
      $display("FAIL done_gap%0d: pulses=%0d at %0d want 1 at %0d", gap, done_n, done_cyc, last + 1);
    end
    vec_cnt++;
    if (late_rdy !== 0) begin
      err_cnt++;
      $display("FAIL extra_ready_gap%0d: got %0d cycles want 0", gap, late_rdy);
    end
  endtask

  task automatic test_abort;
    int done_n;
    done_n = 0;
    a_start = 1'b1;
    tick;
    a_start = 1'b0;
    a_valid = 1'b1;
    a_data  = 16'hA5C3;
    for (int c = 2; c <= 8; c++) begin
      tick;
      a_valid = 1'b0;
    end
    vec_cnt++;
    if (a_shift_en !== 1'b1) begin
      err_cnt++;
      $display("FAIL abort_pre: shift_en=%b want 1", a_shift_en);
    end
    a_abort = 1'b1;
    tick;
    vec_cnt++;
    if ({a_shift_en, a_busy, a_ready, a_done} !== 4'b0) begin
      err_cnt++;
      $display("FAIL abort_next: shift_en,busy,ready,done=%b want 0000", {a_shift_en, a_busy, a_ready, a_done});
    end
    a_abort = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick;
      if (a_done || a_busy) done_n++;
    end
    vec_cnt++;
    if (done_n !== 0) begin
      err_cnt++;
      $display("FAIL abort_quiet: done/busy seen %0d cycles want 0", done_n);
    end
    a_start = 1'b1;
    a_abort = 1'b1;
    tick;
    a_start = 1'b0;
    a_abort = 1'b0;
    vec_cnt++;
    if (a_busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL start_abort_idle: busy=%b want 0", a_busy);
    end
    test_single_word(16'h5A3C);
  endtask

  task automatic test_reset_mid;
    a_start = 1'b1;
    tick;
    a_start = 1'b0;
    a_valid = 1'b1;
    a_data  = 16'hFFFF;
    for (int c = 2; c <= 5; c++) begin
      tick;
      a_valid = 1'b0;
    end
    vec_cnt++;
    if ({a_head, a_shift_en} !== 2'b11) begin
      err_cnt++;
      $display("FAIL rst_pre: head,shift_en=%b want 11", {a_head, a_shift_en});
    end
    prog_reset_n = 1'b0;
    #1;
    vec_cnt++;
    if ({a_head, a_shift_en, a_busy, a_ready, a_done} !== 5'b0) begin
      err_cnt++;
      $display("FAIL rst_async: outputs=%b want 00000", {a_head, a_shift_en, a_busy, a_ready, a_done});
    end
    a_start = 1'b1;
    tick;
    tick;
    vec_cnt++;
    if ({a_busy, a_ready} !== 2'b00) begin
      err_cnt++;
      $display("FAIL rst_start_ignored: busy,ready=%b want 00", {a_busy, a_ready});
    end
    a_start = 1'b0;
    prog_reset_n = 1'b1;
    tick;
    vec_cnt++;
    if (a_busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL rst_release: busy=%b want 0", a_busy);
    end
  endtask

`ifdef CCFF_READBACK_EN
  task automatic test_readback;
    logic [15:0] words [2];
    logic [15:0] exp_rb [2];
    words[0] = 16'h1234; words[1] = 16'hFFFF;
    exp_rb[0] = 16'h0000; exp_rb[1] = 16'h1234;
    chain_clr = 1'b1;
    tick;
    chain_clr = 1'b0;
    for (int n = 0; n < 2; n++) begin
      a_start = 1'b1;
      tick;
      a_start = 1'b0;
      a_valid = 1'b1;
      a_data  = words[n];
      for (int c = 2; c <= 17; c++) begin
        tick;
        a_valid = 1'b0;
      end
      vec_cnt++;
      if (a_rb_valid !== 1'b0) begin
        err_cnt++;
        $display("FAIL rb_early%0d: rb_valid=%b want 0", n, a_rb_valid);
      end
      tick;
      vec_cnt++;
      if ({a_rb_valid, a_rb_data} !== {1'b1, exp_rb[n]}) begin
        err_cnt++;
        $display("FAIL rb_word%0d: rb_valid=%b rb_data=%h want 1 %h", n, a_rb_valid, a_rb_data, exp_rb[n]);
      end
      tick;
    end
  endtask
`endif

  initial begin
    test_reset;
    test_single_word(16'hA5C3);
    test_two_words(0);
    test_two_words(3);
    test_abort;
    test_reset_mid;
`ifdef CCFF_READBACK_EN
    test_readback;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
